// File: rtl/wb_exc_commit_pkg.sv
// Shared definitions for the writeback exception/commit controller:
// MIPS ExcCode values, exception flag bit positions and FSM states.
package wb_exc_commit_pkg;

    localparam logic [4:0] EXCCODE_INT  = 5'd0;
    localparam logic [4:0] EXCCODE_ADEL = 5'd4;
    localparam logic [4:0] EXCCODE_ADES = 5'd5;
    localparam logic [4:0] EXCCODE_SYS  = 5'd8;
    localparam logic [4:0] EXCCODE_BP   = 5'd9;
    localparam logic [4:0] EXCCODE_RI   = 5'd10;
    localparam logic [4:0] EXCCODE_OV   = 5'd12;

    localparam int FLAG_ADEL_IF = 0;
    localparam int FLAG_RI      = 1;
    localparam int FLAG_OV      = 2;
    localparam int FLAG_SYS     = 3;
    localparam int FLAG_BP      = 4;
    localparam int FLAG_ADEL_D  = 5;
    localparam int FLAG_ADES    = 6;
    localparam int NUM_FLAGS    = 7;

    typedef enum logic {
        ST_RUN      = 1'b0,
        ST_REDIRECT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_exc_commit_prio.sv
// Exception priority encoder: picks the highest-priority cause and
// reports which address (fetch PC or data address) is the bad one.
module exc_prio_enc
    import wb_exc_commit_pkg::*;
(
    input  logic                 int_pend,
    input  logic [NUM_FLAGS-1:0] flags,
    output logic                 exc,
    output logic [4:0]           excode,
    output logic                 sel_data_addr,
    output logic                 sel_pc_addr
);

    always_comb begin
        exc           = int_pend | (|flags);
        excode        = EXCCODE_INT;
        sel_data_addr = 1'b0;
        sel_pc_addr   = 1'b0;
        // Several flags may be set at once; the first match wins.
        priority case (1'b1)
            int_pend: excode = EXCCODE_INT;
            flags[FLAG_ADEL_IF]: begin
                excode      = EXCCODE_ADEL;
                sel_pc_addr = 1'b1;
            end
            flags[FLAG_RI]:  excode = EXCCODE_RI;
            flags[FLAG_OV]:  excode = EXCCODE_OV;
            flags[FLAG_SYS]: excode = EXCCODE_SYS;
            flags[FLAG_BP]:  excode = EXCCODE_BP;
            flags[FLAG_ADEL_D]: begin
                excode        = EXCCODE_ADEL;
                sel_data_addr = 1'b1;
            end
            flags[FLAG_ADES]: begin
                excode        = EXCCODE_ADES;
                sel_data_addr = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/wb_exc_commit.sv
// Writeback stage: holds the WB register, raises exceptions / ERET to
// CP0, and flushes the pipeline while a fetch redirect is pending.
module wb_exc_commit
    import wb_exc_commit_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = 32'hBFC00380,
    parameter int          FLAG_W     = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ms_valid,
    input  logic [31:0]       ms_pc,
    input  logic              ms_bd,
    input  logic [FLAG_W-1:0] ms_exc_flags,
    input  logic [31:0]       ms_data_addr,
    input  logic              ms_eret,
    output logic              ws_allowin,
    input  logic [7:0]        int_req,
    input  logic              status_ie,
    input  logic              status_exl,
    input  logic [31:0]       cp0_epc,
    output logic              wb_ex,
    output logic [4:0]        wb_excode,
    output logic              wb_bd,
    output logic [31:0]       wb_pc,
    output logic [31:0]       wb_badvaddr,
    output logic              eret_flush,
    output logic              ws_commit,
    output logic              flush,
    output logic              redirect_valid,
    output logic [31:0]       redirect_pc,
    input  logic              redirect_ready
);

    wb_state_t         state;
    logic              ws_valid;
    logic [31:0]       ws_pc;
    logic              ws_bd;
    logic [FLAG_W-1:0] ws_flags;
    logic [31:0]       ws_data_addr;
    logic              ws_eret;

    logic              int_pend;
    logic              exc;
    logic [4:0]        excode;
    logic              sel_data_addr;
    logic              sel_pc_addr;
    logic              in_run;

    assign int_pend = (|int_req) & status_ie & ~status_exl;

    exc_prio_enc u_prio (
        .int_pend      (int_pend),
        .flags         (ws_flags),
        .exc           (exc),
        .excode        (excode),
        .sel_data_addr (sel_data_addr),
        .sel_pc_addr   (sel_pc_addr)
    );

    assign in_run         = (state == ST_RUN);
    assign wb_ex          = in_run & ws_valid & exc;
    assign eret_flush     = in_run & ws_valid & ws_eret & ~exc;
    assign ws_commit      = in_run & ws_valid & ~exc & ~ws_eret;
    assign ws_allowin     = in_run & ~(ws_valid & (exc | ws_eret));
    assign redirect_valid = (state == ST_REDIRECT);
    assign flush          = wb_ex | eret_flush | redirect_valid;

    assign wb_excode = wb_ex ? excode : 5'd0;
    assign wb_bd     = wb_ex & ws_bd;
    assign wb_pc     = wb_ex ? ws_pc : 32'd0;

    always_comb begin
        wb_badvaddr = 32'd0;
        if (wb_ex && sel_data_addr)
            wb_badvaddr = ws_data_addr;
        else if (wb_ex && sel_pc_addr)
            wb_badvaddr = ws_pc;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            redirect_pc <= 32'd0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (wb_ex) begin
                        redirect_pc <= EXC_VECTOR;
                        state       <= ST_REDIRECT;
                    end else if (eret_flush) begin
                        redirect_pc <= cp0_epc;
                        state       <= ST_REDIRECT;
                    end
                end
                ST_REDIRECT: begin
                    if (redirect_ready)
                        state <= ST_RUN;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ws_valid     <= 1'b0;
            ws_pc        <= 32'd0;
            ws_bd        <= 1'b0;
            ws_flags     <= '0;
            ws_data_addr <= 32'd0;
            ws_eret      <= 1'b0;
        end else if (ws_allowin) begin
            ws_valid     <= ms_valid;
            ws_pc        <= ms_pc;
            ws_bd        <= ms_bd;
            ws_flags     <= ms_exc_flags;
            ws_data_addr <= ms_data_addr;
            ws_eret      <= ms_eret;
        end else if (wb_ex || eret_flush) begin
            ws_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_exc_commit.sv
// Bench for wb_exc_commit: directed scenarios then random traffic,
// checked cycle by cycle against a transaction-level reference model.
module tb_wb_exc_commit;

    localparam logic [31:0] VEC = 32'hBFC00380;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ms_valid = 1'b0;
    logic [31:0] ms_pc = '0;
    logic        ms_bd = 1'b0;
    logic [6:0]  ms_exc_flags = '0;
    logic [31:0] ms_data_addr = '0;
    logic        ms_eret = 1'b0;
    logic        ws_allowin;
    logic [7:0]  int_req = '0;
    logic        status_ie = 1'b0;
    logic        status_exl = 1'b0;
    logic [31:0] cp0_epc = '0;
    logic        wb_ex;
    logic [4:0]  wb_excode;
    logic        wb_bd;
    logic [31:0] wb_pc;
    logic [31:0] wb_badvaddr;
    logic        eret_flush;
    logic        ws_commit;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready = 1'b1;

    always #5 clk = ~clk;

    wb_exc_commit dut (
        .clk            (clk),
        .reset          (reset),
        .ms_valid       (ms_valid),
        .ms_pc          (ms_pc),
        .ms_bd          (ms_bd),
        .ms_exc_flags   (ms_exc_flags),
        .ms_data_addr   (ms_data_addr),
        .ms_eret        (ms_eret),
        .ws_allowin     (ws_allowin),
        .int_req        (int_req),
        .status_ie      (status_ie),
        .status_exl     (status_exl),
        .cp0_epc        (cp0_epc),
        .wb_ex          (wb_ex),
        .wb_excode      (wb_excode),
        .wb_bd          (wb_bd),
        .wb_pc          (wb_pc),
        .wb_badvaddr    (wb_badvaddr),
        .eret_flush     (eret_flush),
        .ws_commit      (ws_commit),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .redirect_ready (redirect_ready)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic        bd;
        logic [6:0]  flags;
        logic [31:0] daddr;
        logic        eret;
    } ins_t;

    ins_t        m_q[$];
    bit          m_redir = 1'b0;
    logic [31:0] m_rpc = '0;
    bit          m_acc = 1'b0;
    int          n_tests = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Cause selection straight from the priority list, highest first.
    function automatic void ref_exc(input ins_t i, input bit intp,
                                    output bit exc, output logic [4:0] code,
                                    output logic [31:0] bad);
        exc = 1'b1;
        bad = 32'd0;
        code = 5'd0;
        if (intp)               code = 5'd0;
        else if (i.flags[0]) begin code = 5'd4; bad = i.pc; end
        else if (i.flags[1])    code = 5'd10;
        else if (i.flags[2])    code = 5'd12;
        else if (i.flags[3])    code = 5'd8;
        else if (i.flags[4])    code = 5'd9;
        else if (i.flags[5]) begin code = 5'd4; bad = i.daddr; end
        else if (i.flags[6]) begin code = 5'd5; bad = i.daddr; end
        else exc = 1'b0;
    endfunction

    task automatic cyc();
        bit          head, exc, intp, e_ex, e_er, e_cm, e_al;
        bit          s_rst, s_rdy;
        logic [4:0]  code;
        logic [31:0] bad, s_epc;
        ins_t        h, mi;
        #1;
        intp = (int_req != 8'd0) && status_ie && !status_exl;
        head = !m_redir && (m_q.size() != 0);
        exc = 1'b0; code = '0; bad = '0; h = '0;
        if (head) begin
            h = m_q[0];
            ref_exc(h, intp, exc, code, bad);
        end
        e_ex = head && exc;
        e_er = head && !exc && h.eret;
        e_cm = head && !exc && !h.eret;
        e_al = !m_redir && !e_ex && !e_er;
        chk("wb_ex", 32'(wb_ex), 32'(e_ex));
        chk("eret_flush", 32'(eret_flush), 32'(e_er));
        chk("ws_commit", 32'(ws_commit), 32'(e_cm));
        chk("ws_allowin", 32'(ws_allowin), 32'(e_al));
        chk("flush", 32'(flush), 32'(m_redir || e_ex || e_er));
        chk("redirect_valid", 32'(redirect_valid), 32'(m_redir));
        chk("redirect_pc", redirect_pc, m_rpc);
        if (e_ex) begin
            chk("wb_excode", 32'(wb_excode), 32'(code));
            chk("wb_bd", 32'(wb_bd), 32'(h.bd));
            chk("wb_pc", wb_pc, h.pc);
            chk("wb_badvaddr", wb_badvaddr, bad);
        end
        s_rst = reset;
        s_rdy = redirect_ready;
        s_epc = cp0_epc;
        mi = '{ms_pc, ms_bd, ms_exc_flags, ms_data_addr, ms_eret};
        m_acc = e_al && ms_valid;
        @(posedge clk);
        if (s_rst) begin
            m_q.delete();
            m_redir = 1'b0;
            m_rpc = '0;
        end else if (m_redir) begin
            if (s_rdy) m_redir = 1'b0;
        end else begin
            if (head) begin
                void'(m_q.pop_front());
                if (e_ex) begin m_redir = 1'b1; m_rpc = VEC; end
                else if (e_er) begin m_redir = 1'b1; m_rpc = s_epc; end
            end
            if (m_acc) m_q.push_back(mi);
        end
        #2;
    endtask

    task automatic send(input logic [31:0] pc, input logic bd,
                        input logic [6:0] fl, input logic [31:0] da,
                        input logic er);
        ms_valid = 1'b1;
        ms_pc = pc;
        ms_bd = bd;
        ms_exc_flags = fl;
        ms_data_addr = da;
        ms_eret = er;
        for (int k = 0; k < 20; k++) begin
            cyc();
            if (m_acc) break;
        end
        chk("send_accept", 32'(m_acc), 32'd1);
        ms_valid = 1'b0;
        ms_exc_flags = '0;
        ms_eret = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b0;
        cyc();

        // 1: plain ALU instruction retires
        send(32'hBFC00100, 1'b0, 7'd0, 32'd0, 1'b0);
        chk("t1_commit", 32'(ws_commit), 32'd1);
        chk("t1_flush", 32'(flush), 32'd0);
        cyc();

        // 2: overflow in a delay slot
        send(32'h80000010, 1'b1, 7'b0000100, 32'd0, 1'b0);
        chk("t2_ex", 32'(wb_ex), 32'd1);
        chk("t2_code", 32'(wb_excode), 32'd12);
        chk("t2_bd", 32'(wb_bd), 32'd1);
        chk("t2_commit", 32'(ws_commit), 32'd0);
        cyc();
        chk("t2_rpc", redirect_pc, 32'hBFC00380);
        cyc();

        // 3: AdES masked by a pending interrupt, then alone
        int_req = 8'h01; status_ie = 1'b1; status_exl = 1'b0;
        send(32'h80000020, 1'b0, 7'b1000000, 32'h00001003, 1'b0);
        chk("t3_int_code", 32'(wb_excode), 32'd0);
        cyc(); cyc();
        int_req = 8'h00;
        send(32'h80000024, 1'b0, 7'b1000000, 32'h00001003, 1'b0);
        chk("t3_ades_code", 32'(wb_excode), 32'd5);
        chk("t3_badvaddr", wb_badvaddr, 32'h00001003);
        cyc(); cyc();

        // 4: ERET with a slow fetch
        redirect_ready = 1'b0;
        cp0_epc = 32'hBFC00700;
        send(32'h80000030, 1'b0, 7'd0, 32'd0, 1'b1);
        chk("t4_eret", 32'(eret_flush), 32'd1);
        cyc();
        for (int k = 0; k < 3; k++) begin
            chk("t4_rv_hold", 32'(redirect_valid), 32'd1);
            chk("t4_allowin", 32'(ws_allowin), 32'd0);
            chk("t4_eret_once", 32'(eret_flush), 32'd0);
            cyc();
        end
        redirect_ready = 1'b1;
        chk("t4_rv_last", 32'(redirect_valid), 32'd1);
        chk("t4_rpc", redirect_pc, 32'hBFC00700);
        cyc();
        chk("t4_rv_drop", 32'(redirect_valid), 32'd0);

        // 5: interrupt blocked by EXL, then taken
        int_req = 8'h80; status_ie = 1'b1; status_exl = 1'b1;
        send(32'h80000040, 1'b0, 7'd0, 32'd0, 1'b0);
        chk("t5_no_ex", 32'(wb_ex), 32'd0);
        cyc();
        status_exl = 1'b0;
        cyc();
        send(32'h80000044, 1'b0, 7'd0, 32'd0, 1'b0);
        chk("t5_ex", 32'(wb_ex), 32'd1);
        chk("t5_code", 32'(wb_excode), 32'd0);
        cyc(); cyc();
        int_req = 8'h00;

        // 6: reset while redirecting
        redirect_ready = 1'b0;
        send(32'h80000050, 1'b0, 7'b0001000, 32'd0, 1'b0);
        cyc();
        chk("t6_in_redir", 32'(redirect_valid), 32'd1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        chk("t6_rv", 32'(redirect_valid), 32'd0);
        chk("t6_flush", 32'(flush), 32'd0);
        chk("t6_allowin", 32'(ws_allowin), 32'd1);
        redirect_ready = 1'b1;
        cyc();

        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 99) == 0);
            ms_valid = 1'($urandom_range(0, 1));
            ms_pc = $urandom;
            ms_bd = 1'($urandom_range(0, 1));
            ms_exc_flags = ($urandom_range(0, 2) == 0) ? 7'($urandom) : 7'd0;
            ms_data_addr = $urandom;
            ms_eret = ($urandom_range(0, 4) == 0);
            int_req = ($urandom_range(0, 5) == 0) ? 8'($urandom) : 8'd0;
            status_ie = 1'($urandom_range(0, 1));
            status_exl = ($urandom_range(0, 3) == 0);
            cp0_epc = $urandom;
            redirect_ready = ($urandom_range(0, 2) != 0);
            cyc();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
